// File: rtl/irq_trap_ctrl.sv
// irq_trap_ctrl: machine-mode interrupt/trap controller.
//   Takes the CLINT software and timer IRQ levels plus an asynchronous
//   external IRQ. Holds mstatus.MIE/MPIE, mie, mip, mtvec, mepc and mcause.
//   It picks the highest-priority enabled interrupt and raises a held trap
//   request. It commits trap state on trap_ack and restores MIE on mret.
// Ports:
//   clk, reset (async, active-low)
//   msw_irq, mtimer_irq : CLINT levels, synchronous to clk
//   mext_irq            : external IRQ level, asynchronous
//   csr_we/csr_addr/csr_wdata/csr_rdata : CSR access; the read is combinational
//   epc_in, trap_ack, mret : pipeline handshake
//   trap_req, trap_pc, mepc_out : trap request, handler target, return target
module irq_trap_ctrl #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        msw_irq,
  input  logic        mtimer_irq,
  input  logic        mext_irq,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  input  logic [31:0] epc_in,
  input  logic        trap_ack,
  input  logic        mret,
  output logic        trap_req,
  output logic [31:0] trap_pc,
  output logic [31:0] mepc_out
);

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MIP     = 12'h344;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_t;

  // MODE values 2 and 3 are stored as direct mode (0). The stored bit 1 is always 0.
  function automatic logic [31:0] legal_mtvec(input logic [31:0] d);
    return {d[31:2], 1'b0, d[0] & ~d[1]};
  endfunction

  state_t                 state_r, state_nxt_s;
  logic [SYNC_STAGES-1:0] ext_sync_r;
  logic                   msip_r, mtip_r;
  logic                   mie_bit_r, mpie_r;
  logic                   msie_r, mtie_r, meie_r;
  logic [31:0]            mtvec_r, mepc_r, mcause_r, trap_pc_r;
  logic [3:0]             code_r, win_code_s;
  logic                   trap_req_r, trap_req_nxt_s;
  logic                   meip_s, fire_s, latch_s, commit_s, mret_ok_s;
  logic [2:0]             pend_s;
  logic [31:0]            vec_pc_s;

  assign meip_s = ext_sync_r[SYNC_STAGES-1];
  assign pend_s = {meip_s & meie_r, msip_r & msie_r, mtip_r & mtie_r};
  assign fire_s = mie_bit_r & (|pend_s);

  // Winner code and handler target. The order is MEI, then MSI, then MTI.
  always_comb begin
    if (pend_s[2]) begin
      win_code_s = 4'd11;
    end else if (pend_s[1]) begin
      win_code_s = 4'd3;
    end else if (pend_s[0]) begin
      win_code_s = 4'd7;
    end else begin
      win_code_s = 4'd0;
    end
    if (mtvec_r[0]) begin
      vec_pc_s = {mtvec_r[31:2], 2'b00} + {26'd0, win_code_s, 2'b00};
    end else begin
      vec_pc_s = {mtvec_r[31:2], 2'b00};
    end
  end

  // Next state and trap request.
  always_comb begin
    state_nxt_s    = state_r;
    trap_req_nxt_s = trap_req_r;
    latch_s        = 1'b0;
    commit_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (fire_s) begin
          state_nxt_s    = ST_REQ;
          trap_req_nxt_s = 1'b1;
          latch_s        = 1'b1;
        end else begin
          trap_req_nxt_s = 1'b0;
        end
      end
      ST_REQ: begin
        if (trap_ack) begin
          state_nxt_s    = ST_IDLE;
          trap_req_nxt_s = 1'b0;
          commit_s       = 1'b1;
        end else begin
          trap_req_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        trap_req_nxt_s = 1'b0;
      end
    endcase
  end

  assign mret_ok_s = mret & (state_r == ST_IDLE);

  // Synchroniser for the external IRQ and registered copies of the CLINT levels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ext_sync_r <= '0;
      msip_r     <= 1'b0;
      mtip_r     <= 1'b0;
    end else begin
      ext_sync_r <= {ext_sync_r[SYNC_STAGES-2:0], mext_irq};
      msip_r     <= msw_irq;
      mtip_r     <= mtimer_irq;
    end
  end

  // FSM state. The code and target are latched at fire and held while in REQ.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      trap_req_r <= 1'b0;
      code_r     <= 4'd0;
      trap_pc_r  <= {MTVEC_RESET[31:2], 2'b00};
    end else begin
      state_r    <= state_nxt_s;
      trap_req_r <= trap_req_nxt_s;
      if (latch_s) begin
        code_r    <= win_code_s;
        trap_pc_r <= vec_pc_s;
      end
    end
  end

  // CSR state. A trap commit overrides a same-cycle write to mstatus, mepc or mcause.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mie_bit_r <= 1'b0;
      mpie_r    <= 1'b0;
      msie_r    <= 1'b0;
      mtie_r    <= 1'b0;
      meie_r    <= 1'b0;
      mtvec_r   <= legal_mtvec(MTVEC_RESET);
      mepc_r    <= 32'd0;
      mcause_r  <= 32'd0;
    end else begin
      if (commit_s) begin
        mpie_r    <= mie_bit_r;
        mie_bit_r <= 1'b0;
        mepc_r    <= epc_in & 32'hFFFF_FFFC;
        mcause_r  <= {1'b1, 27'd0, code_r};
      end else if (mret_ok_s) begin
        mie_bit_r <= mpie_r;
        mpie_r    <= 1'b1;
      end else if (csr_we && csr_addr == A_MSTATUS) begin
        mie_bit_r <= csr_wdata[3];
        mpie_r    <= csr_wdata[7];
      end else if (csr_we && csr_addr == A_MEPC) begin
        mepc_r    <= csr_wdata & 32'hFFFF_FFFC;
      end else if (csr_we && csr_addr == A_MCAUSE) begin
        mcause_r  <= csr_wdata;
      end
      if (csr_we && csr_addr == A_MIE) begin
        msie_r <= csr_wdata[3];
        mtie_r <= csr_wdata[7];
        meie_r <= csr_wdata[11];
      end
      if (csr_we && csr_addr == A_MTVEC) begin
        mtvec_r <= legal_mtvec(csr_wdata);
      end
    end
  end

  // Combinational CSR read mux.
  always_comb begin
    case (csr_addr)
      A_MSTATUS: csr_rdata = {24'd0, mpie_r, 3'd0, mie_bit_r, 3'd0};
      A_MIE:     csr_rdata = {20'd0, meie_r, 3'd0, mtie_r, 3'd0, msie_r, 3'd0};
      A_MIP:     csr_rdata = {20'd0, meip_s, 3'd0, mtip_r, 3'd0, msip_r, 3'd0};
      A_MTVEC:   csr_rdata = mtvec_r;
      A_MEPC:    csr_rdata = mepc_r;
      A_MCAUSE:  csr_rdata = mcause_r;
      default:   csr_rdata = 32'd0;
    endcase
  end

  assign trap_req = trap_req_r;
  assign trap_pc  = trap_pc_r;
  assign mepc_out = mepc_r;

endmodule

// File: tb/tb_irq_trap_ctrl.sv
module tb_irq_trap_ctrl;
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        reset, msw_irq, mtimer_irq, mext_irq, csr_we, trap_ack, mret;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata, epc_in, trap_pc, mepc_out;
  logic        trap_req;

  irq_trap_ctrl #(.SYNC_STAGES(SYNC), .MTVEC_RESET(32'h0000_0100)) dut (
    .clk(clk), .reset(reset), .msw_irq(msw_irq), .mtimer_irq(mtimer_irq),
    .mext_irq(mext_irq), .csr_we(csr_we), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .epc_in(epc_in),
    .trap_ack(trap_ack), .mret(mret), .trap_req(trap_req),
    .trap_pc(trap_pc), .mepc_out(mepc_out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advances n clock edges and stops 1 time unit after the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csr_addr = a; csr_wdata = d; csr_we = 1'b1;
    step(1);
    csr_we = 1'b0;
  endtask

  task automatic check_csr(input string name, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    check(name, csr_rdata, exp);
  endtask

  task automatic ack(input logic [31:0] epc);
    epc_in = epc; trap_ack = 1'b1;
    step(1);
    trap_ack = 1'b0;
  endtask

  task automatic pulse_mret();
    mret = 1'b1;
    step(1);
    mret = 1'b0;
  endtask

  task automatic wait_req(input int budget, input string name);
    for (int i = 0; i < budget && !trap_req; i++) step(1);
    check(name, {31'd0, trap_req}, 32'd1);
  endtask

  // Reference model: given IRQ levels {ext,tim,sw} and enables, return fire and code.
  function automatic bit model_trap(input logic [2:0] lv, input logic [2:0] en,
                                    input bit gmie, output int code);
    int  prio_code[3] = '{11, 3, 7};
    int  prio_src[3]  = '{2, 0, 1};
    code = 0;
    if (!gmie) return 1'b0;
    foreach (prio_src[k]) begin
      if (lv[prio_src[k]] && en[prio_src[k]]) begin
        code = prio_code[k];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  initial begin
    logic [2:0]  lv, en;
    bit          gmie, exp_fire;
    int          code;
    logic [31:0] tv, tv_exp, base, epc, pc_exp, mip_exp, mie_w;

    reset = 1'b0; msw_irq = 1'b0; mtimer_irq = 1'b0; mext_irq = 1'b0;
    csr_we = 1'b0; csr_addr = 12'h000; csr_wdata = 32'd0; epc_in = 32'd0;
    trap_ack = 1'b0; mret = 1'b0;
    #22 reset = 1'b1;
    step(1);

    // Reset state
    check("rst_trap_req", {31'd0, trap_req}, 32'd0);
    check_csr("rst_mstatus", 12'h300, 32'd0);
    check_csr("rst_mie", 12'h304, 32'd0);
    check_csr("rst_mepc", 12'h341, 32'd0);
    check_csr("rst_mcause", 12'h342, 32'd0);
    check_csr("rst_mtvec", 12'h305, 32'h100);

    // CSR write/readback table
    tbl[0]  = '{12'h305, 32'h0000_0103, 32'h0000_0100};
    tbl[1]  = '{12'h305, 32'h0000_0102, 32'h0000_0100};
    tbl[2]  = '{12'h305, 32'h0000_0201, 32'h0000_0201};
    tbl[3]  = '{12'h341, 32'h0000_1237, 32'h0000_1234};
    tbl[4]  = '{12'h342, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tbl[5]  = '{12'h304, 32'hFFFF_FFFF, 32'h0000_0888};
    tbl[6]  = '{12'h300, 32'hFFFF_FF77, 32'h0000_0000};
    tbl[7]  = '{12'h300, 32'hFFFF_FFFF, 32'h0000_0088};
    tbl[8]  = '{12'h344, 32'h0000_0FFF, 32'h0000_0000};
    tbl[9]  = '{12'h123, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[10] = '{12'h300, 32'h0000_0000, 32'h0000_0000};
    tbl[11] = '{12'h304, 32'h0000_0000, 32'h0000_0000};
    tbl[12] = '{12'h305, 32'h0000_0100, 32'h0000_0100};
    foreach (tbl[i]) begin
      csr_write(tbl[i].addr, tbl[i].wdata);
      check_csr($sformatf("tbl%0d_%03h", i, tbl[i].addr), tbl[i].addr, tbl[i].exp);
    end
    check_csr("tbl_mepc_kept", 12'h341, 32'h1234);

    // Timer trap, direct mode
    csr_write(12'h304, 32'h80);
    csr_write(12'h300, 32'h8);
    mtimer_irq = 1'b1;
    step(1);
    check("timer_1clk", {31'd0, trap_req}, 32'd0);
    step(1);
    check("timer_2clk", {31'd0, trap_req}, 32'd1);
    check("timer_pc", trap_pc, 32'h100);
    ack(32'h2004);
    check("timer_req_drop", {31'd0, trap_req}, 32'd0);
    check_csr("timer_mepc", 12'h341, 32'h2004);
    check("timer_mepc_out", mepc_out, 32'h2004);
    check_csr("timer_mcause", 12'h342, 32'h8000_0007);
    check_csr("timer_mstatus", 12'h300, 32'h80);

    // mret restores MIE and sets MPIE
    mtimer_irq = 1'b0;
    step(2);
    pulse_mret();
    check_csr("mret_mstatus", 12'h300, 32'h88);

    // Hold in REQ, then a mepc write in the ack cycle loses to the commit
    mtimer_irq = 1'b1;
    wait_req(4, "hold_req_up");
    mtimer_irq = 1'b0;
    csr_write(12'h300, 32'h0);
    step(3);
    check("hold_req_held", {31'd0, trap_req}, 32'd1);
    csr_addr = 12'h341; csr_wdata = 32'h5555; csr_we = 1'b1;
    ack(32'h3000);
    csr_we = 1'b0;
    check_csr("hold_mepc_commit", 12'h341, 32'h3000);
    check_csr("hold_mcause", 12'h342, 32'h8000_0007);
    check_csr("hold_mstatus", 12'h300, 32'h0);

    // Priority, vectored mode
    csr_write(12'h305, 32'h101);
    csr_write(12'h304, 32'h888);
    msw_irq = 1'b1; mtimer_irq = 1'b1; mext_irq = 1'b1;
    step(SYNC + 2);
    check("prio_no_fire_mie0", {31'd0, trap_req}, 32'd0);
    csr_write(12'h300, 32'h8);
    wait_req(4, "prio_req_up");
    check("prio_pc_mei", trap_pc, 32'h12C);
    ack(32'h4000);
    check_csr("prio_mcause_mei", 12'h342, 32'h8000_000B);
    mext_irq = 1'b0;
    step(SYNC + 2);
    pulse_mret();
    wait_req(4, "prio_req2_up");
    check("prio_pc_msi", trap_pc, 32'h10C);
    ack(32'h4100);
    check_csr("prio_mcause_msi", 12'h342, 32'h8000_0003);
    msw_irq = 1'b0; mtimer_irq = 1'b0;
    csr_write(12'h300, 32'h0);
    csr_write(12'h304, 32'h0);
    csr_write(12'h305, 32'h100);
    step(SYNC + 2);

    // Randomised scenarios against the reference model
    for (int it = 0; it < 40; it++) begin
      lv   = 3'($urandom_range(0, 7));
      en   = 3'($urandom_range(0, 7));
      gmie = 1'($urandom_range(0, 1));
      tv   = $urandom;
      epc  = $urandom;
      msw_irq = lv[0]; mtimer_irq = lv[1]; mext_irq = lv[2];
      mie_w = 32'd0;
      mie_w[3] = en[0]; mie_w[7] = en[1]; mie_w[11] = en[2];
      csr_write(12'h305, tv);
      csr_write(12'h304, mie_w);
      step(SYNC + 1);
      tv_exp = tv & 32'hFFFF_FFFC;
      if (tv[1:0] == 2'b01) tv_exp[0] = 1'b1;
      check_csr($sformatf("rnd%0d_mtvec", it), 12'h305, tv_exp);
      mip_exp = 32'd0;
      mip_exp[3] = lv[0]; mip_exp[7] = lv[1]; mip_exp[11] = lv[2];
      check_csr($sformatf("rnd%0d_mip", it), 12'h344, mip_exp);
      csr_write(12'h300, gmie ? 32'h8 : 32'h0);
      step(4);
      exp_fire = model_trap(lv, en, gmie, code);
      check($sformatf("rnd%0d_req", it), {31'd0, trap_req}, {31'd0, exp_fire});
      if (exp_fire) begin
        base   = tv & 32'hFFFF_FFFC;
        pc_exp = (tv[1:0] == 2'b01) ? base + 32'(code * 4) : base;
        check($sformatf("rnd%0d_pc", it), trap_pc, pc_exp);
        ack(epc);
        check_csr($sformatf("rnd%0d_mcause", it), 12'h342, 32'h8000_0000 | 32'(code));
        check_csr($sformatf("rnd%0d_mepc", it), 12'h341, epc & 32'hFFFF_FFFC);
        check_csr($sformatf("rnd%0d_mstatus", it), 12'h300, 32'h80);
      end
      msw_irq = 1'b0; mtimer_irq = 1'b0; mext_irq = 1'b0;
      csr_write(12'h300, 32'h0);
      step(SYNC + 1);
    end

    // A glitch on mext_irq between edges is never sampled
    csr_write(12'h305, 32'h100);
    csr_write(12'h304, 32'h800);
    csr_write(12'h300, 32'h8);
    @(negedge clk);
    #1 mext_irq = 1'b1;
    #2 mext_irq = 1'b0;
    step(SYNC + 3);
    check("glitch_no_trap", {31'd0, trap_req}, 32'd0);

    // Async reset asserted mid-REQ
    mext_irq = 1'b1;
    wait_req(SYNC + 4, "arst_req_up");
    #2 reset = 1'b0;
    #1;
    check("arst_req_low", {31'd0, trap_req}, 32'd0);
    check_csr("arst_mstatus", 12'h300, 32'd0);
    check_csr("arst_mtvec", 12'h305, 32'h100);
    check("arst_trap_pc", trap_pc, 32'h100);
    mext_irq = 1'b0;
    step(1);
    reset = 1'b1;
    step(SYNC + 2);
    check("arst_after_release", {31'd0, trap_req}, 32'd0);
    check_csr("arst_mie", 12'h304, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
